// File: rtl/mult_div_ctrl.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit.
// One iteration per cycle. hi:lo holds the last result until the next operation completes.
module mult_div_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_q;
  logic [W-1:0]     acc_q;   // Booth accumulator / division remainder
  logic [W-1:0]     q_q;     // multiplier / dividend shifting into quotient
  logic             q1_q;
  logic [W-1:0]     m_q;     // multiplicand / divisor magnitude
  logic             qneg_q;
  logic             rneg_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [W-1:0]     hi_q;
  logic [W-1:0]     lo_q;

  logic [W:0]   acc_ext;
  logic [W:0]   m_ext;
  logic [W:0]   booth_sum;
  logic [W-1:0] mul_acc_d;
  logic [W-1:0] mul_q_d;
  logic [W:0]   rem_sh;
  logic [W:0]   trial;
  logic [W-1:0] div_acc_d;
  logic [W-1:0] div_q_d;
  logic [W-1:0] quo_fin;
  logic [W-1:0] rem_fin;

  function automatic logic [W-1:0] neg(input logic [W-1:0] x);
    return ~x + W'(1);
  endfunction

  // Booth step uses a 33-bit sum so that subtracting 0x80000000 cannot overflow.
  always_comb begin
    acc_ext   = {acc_q[W-1], acc_q};
    m_ext     = {m_q[W-1], m_q};
    booth_sum = acc_ext;
    case ({q_q[0], q1_q})
      2'b01:   booth_sum = acc_ext + m_ext;
      2'b10:   booth_sum = acc_ext - m_ext;
      default: booth_sum = acc_ext;
    endcase
    mul_acc_d = booth_sum[W:1];
    mul_q_d   = {booth_sum[0], q_q[W-1:1]};

    rem_sh = {acc_q, q_q[W-1]};
    trial  = rem_sh - {1'b0, m_q};
    if (trial[W]) begin
      div_acc_d = rem_sh[W-1:0];
      div_q_d   = {q_q[W-2:0], 1'b0};
    end else begin
      div_acc_d = trial[W-1:0];
      div_q_d   = {q_q[W-2:0], 1'b1};
    end
    quo_fin = qneg_q ? neg(div_q_d) : div_q_d;
    rem_fin = rneg_q ? neg(div_acc_d) : div_acc_d;
  end

  // done/div_zero are registered from the DONE state, so they rise one edge after entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            cnt_q <= '0;
            acc_q <= '0;
            q1_q  <= 1'b0;
            if (!op) begin
              m_q     <= a;
              q_q     <= b;
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= MULT;
            end else begin
              m_q    <= b[W-1] ? neg(b) : b;
              q_q    <= a[W-1] ? neg(a) : a;
              qneg_q <= a[W-1] ^ b[W-1];
              rneg_q <= a[W-1];
              if (b == '0) begin
                state_q <= DONE;
              end else begin
                busy_q  <= 1'b1;
                state_q <= DIV;
              end
            end
          end
        end
        MULT: begin
          acc_q <= mul_acc_d;
          q_q   <= mul_q_d;
          q1_q  <= q_q[0];
          if (cnt_q == LAST_ITER) begin
            cnt_q   <= '0;
            hi_q    <= mul_acc_d;
            lo_q    <= mul_q_d;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DIV: begin
          acc_q <= div_acc_d;
          q_q   <= div_q_d;
          if (cnt_q == LAST_ITER) begin
            cnt_q   <= '0;
            hi_q    <= rem_fin;
            lo_q    <= quo_fin;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          dz_q    <= op_q && (m_q == '0);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: vector table, random model-checked ops,
// and hand sequences for ignored restart and mid-operation reset.
module tb_mult_div_ctrl;

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int   checks;
  int   errors;
  exp_t sb[$];
  vec_t vecs[11];

  mult_div_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation now (between edges), then follow it to its done pulse.
  task automatic run_op(input logic op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                        input exp_t e, input int poke_cyc, input string name);
    int   exp_lat;
    bit   got;
    exp_t x;
    exp_lat = e.dz ? 1 : 33;
    start = 1'b1; op = op_v; a = a_v; b = b_v;
    sb.push_back(e);
    @(posedge clock); #1;
    start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
    check({name, " busy_after_accept"}, 64'(busy), 64'(!e.dz));
    got = 1'b0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      if (cyc == poke_cyc) begin
        start = 1'b1; op = ~op_v; a = 32'h64; b = 32'h5;
      end
      @(posedge clock); #1;
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        x = sb.pop_front();
        check({name, " latency"}, 64'(cyc), 64'(exp_lat));
        check({name, " hi"}, 64'(hi), 64'(x.hi));
        check({name, " lo"}, 64'(lo), 64'(x.lo));
        check({name, " div_zero"}, 64'(div_zero), 64'(x.dz));
        check({name, " busy_at_done"}, 64'(busy), 64'(0));
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s timeout: done not seen, expected within %0d cycles", name, exp_lat);
      void'(sb.pop_front());
    end
    @(posedge clock); #1;
    check({name, " done_pulse_width"}, 64'(done), 64'(0));
    check({name, " div_zero_low"}, 64'(div_zero), 64'(0));
    check({name, " hold"}, {hi, lo}, {e.hi, e.lo});
  endtask

  initial begin
    exp_t e;
    int   dones;
    longint sa, sbv, p;
    int   qa, qb;
    checks = 0; errors = 0;
    start = 1'b0; op = 1'b0; a = '0; b = '0;

    vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{1'b1, 32'h451,      32'h20,       32'h11,       32'h22,       1'b0};
    vecs[5]  = '{1'b1, 32'd5,        32'd0,        32'h11,       32'h22,       1'b1};
    vecs[6]  = '{1'b0, 32'h12345678, 32'd0,        32'h0,        32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        1'b0};
    vecs[8]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[10] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};

    reset = 1'b1;
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset div_zero", 64'(div_zero), 64'(0));
    check("reset hi_lo", {hi, lo}, 64'(0));
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      e = '{vecs[i].hi, vecs[i].lo, vecs[i].dz};
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, e, 0, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      logic        rop;
      logic [31:0] ra, rb;
      rop = 1'($urandom_range(0, 1)); ra = $urandom; rb = $urandom;
      if (rop && (rb == 32'd0 || (ra == 32'h80000000 && rb == 32'hFFFFFFFF))) rb = 32'd3;
      if (!rop) begin
        sa = longint'($signed(ra)); sbv = longint'($signed(rb)); p = sa * sbv;
        e = '{p[63:32], p[31:0], 1'b0};
      end else begin
        qa = $signed(ra); qb = $signed(rb);
        e = '{32'(qa % qb), 32'(qa / qb), 1'b0};
      end
      run_op(rop, ra, rb, e, 0, $sformatf("rand%0d", i));
    end

    // Second start during MULT is ignored and never queued.
    run_op(1'b0, 32'd6, 32'd7, '{32'd0, 32'd42, 1'b0}, 5, "ignored_restart");
    dones = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    check("ignored_restart extra_done", 64'(dones), 64'(0));

    // Reset at iteration 10 abandons the operation.
    start = 1'b1; op = 1'b0; a = 32'd100; b = 32'd200;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("midreset busy", 64'(busy), 64'(0));
    check("midreset hi_lo", {hi, lo}, 64'(0));
    dones = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    check("midreset no_done", 64'(dones), 64'(0));
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    run_op(1'b0, 32'd3, 32'd4, '{32'd0, 32'd12, 1'b0}, 0, "after_reset_mult");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
